control_unit: RTL

Hardwired sequencer for the single-bus CPU datapath. Each clock edge advances one micro-step: fetch, then an execute sequence selected by the IR opcode. The block drives the datapath's one-hot bus-source select (`enc_input`), register load enables (`reg_enable`), ALU select, memory strobes and the Gra/Grb/Grc/Rin/Rout/BAout/conIn select-encode signals. It replaces hand-timed per-instruction control sequences with one clocked controller that sits beside `datapath`.

---
 rtl/control_unit.sv | 317 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Hardwired micro-step sequencer for the single-bus CPU datapath.
// One state per clock: fetch (T0-T2), then an opcode-selected execute sequence.
//
//   state  | meaning
//   RESET  | held while clr=0, all outputs idle
//   T0-T2  | instruction fetch (PC->MAR, PC+1, MDR->IR)
//   T3-T7  | execute steps selected by ir[31:27]
//   MEMW   | extra memory cycles when MEM_LAT > 1
//   HALT   | stopped until clr
module control_unit #(
  parameter int MEM_LAT = 1
) (
  input  logic        clock,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic [31:0] enc_input,
  output logic [31:0] reg_enable,
  output logic [5:0]  ALU_Sel,
  output logic        read,
  output logic        write,
  output logic        incPC,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        conIn,
  output logic        run,
  output logic        illegal,
  output logic [3:0]  state
);

  localparam int CW = $clog2(MEM_LAT) + 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT - 1);

  localparam int B_ZLOW = 19;
  localparam int B_PC   = 20;
  localparam int B_IR   = 21;
  localparam int B_MDR  = 22;
  localparam int B_MAR  = 23;
  localparam int B_Y    = 24;
  localparam int B_C    = 25;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_MEMW  = 4'd9,
    S_HALT  = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    R_FETCH = 2'd0,
    R_LD    = 2'd1,
    R_ST    = 2'd2
  } ret_t;

  state_t        state_q, state_d;
  ret_t          ret_q, ret_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          illegal_q, illegal_d;

  logic [4:0] op;
  logic       legal;
  logic       last_cyc;
  logic       unused_ir;

  assign op        = ir[31:27];
  assign unused_ir = ^ir[26:0];
  assign last_cyc  = (cnt_q == '0);

  always_comb begin
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ADDI, OP_BR, OP_NOP, OP_HALT: legal = 1'b1;
      default:                         legal = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge clr) begin
    if (!clr) begin
      state_q   <= S_RESET;
      ret_q     <= R_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    illegal_d = illegal_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1: begin
        if (last_cyc) state_d = S_T2;
        else begin
          state_d = S_MEMW;
          ret_d   = R_FETCH;
        end
      end
      S_T2:    state_d = S_T3;
      S_T3: begin
        if (!legal) illegal_d = 1'b1;
        if (op == OP_HALT)               state_d = S_HALT;
        else if (op == OP_NOP || !legal) state_d = S_T0;
        else                             state_d = S_T4;
      end
      S_T4:    state_d = S_T5;
      S_T5: begin
        if (op == OP_LD || op == OP_ST || op == OP_BR) state_d = S_T6;
        else                                           state_d = S_T0;
      end
      S_T6: begin
        if (op == OP_LD) begin
          if (last_cyc) state_d = S_T7;
          else begin
            state_d = S_MEMW;
            ret_d   = R_LD;
          end
        end else if (op == OP_ST) begin
          state_d = S_T7;
        end else begin
          state_d = S_T0;
        end
      end
      S_T7: begin
        if (op == OP_ST && !last_cyc) begin
          state_d = S_MEMW;
          ret_d   = R_ST;
        end else begin
          state_d = S_T0;
        end
      end
      S_MEMW: begin
        if (last_cyc) begin
          case (ret_q)
            R_FETCH: state_d = S_T2;
            R_LD:    state_d = S_T7;
            default: state_d = S_T0;
          endcase
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  // Down-counter: loaded one cycle before a memory access, terminal count marks its last cycle.
  always_comb begin
    cnt_d = (cnt_q != '0) ? (cnt_q - CW'(1)) : cnt_q;
    if (state_q == S_T0 || (state_q == S_T5 && op == OP_LD) ||
        (state_q == S_T6 && op == OP_ST))
      cnt_d = LAT_M1;
  end

  always_comb begin
    enc_input  = '0;
    reg_enable = '0;
    ALU_Sel    = '0;
    read       = 1'b0;
    write      = 1'b0;
    incPC      = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    BAout      = 1'b0;
    conIn      = 1'b0;
    case (state_q)
      S_T0: begin
        enc_input[B_PC]    = 1'b1;
        reg_enable[B_MAR]  = 1'b1;
        reg_enable[B_ZLOW] = 1'b1;
        incPC              = 1'b1;
      end
      S_T1: begin
        enc_input[B_ZLOW] = 1'b1;
        reg_enable[B_PC]  = 1'b1;
        read              = 1'b1;
        reg_enable[B_MDR] = last_cyc;
      end
      S_MEMW: begin
        if (ret_q == R_ST) write = 1'b1;
        else begin
          read              = 1'b1;
          reg_enable[B_MDR] = last_cyc;
        end
      end
      S_T2: begin
        enc_input[B_MDR] = 1'b1;
        reg_enable[B_IR] = 1'b1;
      end
      S_T3: begin
        case (op)
          OP_LD, OP_LDI, OP_ST: begin
            Grb             = 1'b1;
            BAout           = 1'b1;
            reg_enable[B_Y] = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
            Grb             = 1'b1;
            Rout            = 1'b1;
            reg_enable[B_Y] = 1'b1;
          end
          OP_BR: begin
            Gra   = 1'b1;
            Rout  = 1'b1;
            conIn = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (op)
          OP_LD, OP_LDI, OP_ST, OP_ADDI: begin
            enc_input[B_C]     = 1'b1;
            reg_enable[B_ZLOW] = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            Grc                = 1'b1;
            Rout               = 1'b1;
            reg_enable[B_ZLOW] = 1'b1;
            if (op == OP_SUB)      ALU_Sel = 6'd1;
            else if (op == OP_AND) ALU_Sel = 6'd2;
            else if (op == OP_OR)  ALU_Sel = 6'd3;
          end
          OP_BR: begin
            enc_input[B_PC] = 1'b1;
            reg_enable[B_Y] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (op)
          OP_LD, OP_ST: begin
            enc_input[B_ZLOW] = 1'b1;
            reg_enable[B_MAR] = 1'b1;
          end
          OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
            enc_input[B_ZLOW] = 1'b1;
            Gra               = 1'b1;
            Rin               = 1'b1;
          end
          OP_BR: begin
            enc_input[B_C]     = 1'b1;
            reg_enable[B_ZLOW] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (op)
          OP_LD: begin
            read              = 1'b1;
            reg_enable[B_MDR] = last_cyc;
          end
          OP_ST: begin
            Gra               = 1'b1;
            Rout              = 1'b1;
            reg_enable[B_MDR] = 1'b1;
          end
          OP_BR: begin
            enc_input[B_ZLOW] = con_ff;
            reg_enable[B_PC]  = con_ff;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (op)
          OP_LD: begin
            enc_input[B_MDR] = 1'b1;
            Gra              = 1'b1;
            Rin              = 1'b1;
          end
          OP_ST:   write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign run     = (state_q != S_RESET) && (state_q != S_HALT);
  assign illegal = illegal_q;
  assign state   = state_q;

endmodule
